wbuf_axi_drain: RTL

- Read-side consumer of the store/write buffer FIFO in the memory subsystem; drains one buffered store at a time onto an AXI4 write channel (AW/W/B).
- Head entry stays resident in the FIFO until its B response returns. The FIFO is popped only on completion, so the head stays visible for forwarding and flush logic.
- Sits between the write-buffer FIFO (empty/read/outdata end) and the AXI crossbar write port.

---
 rtl/wbuf_axi_drain.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/wbuf_axi_drain.sv
// Drains the write-buffer FIFO head onto a single-beat AXI4 write (AW/W/B),
// popping the entry only once its B response has been accepted.
module wbuf_axi_drain #(
  parameter int          ADDR_W   = 32,
  parameter int          DATA_W   = 32,
  parameter logic [3:0]  AXI_ID   = 4'd1,
  parameter logic [2:0]  AXI_SIZE = 3'b010
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fifo_empty,
  input  logic [ADDR_W-1:0]     fifo_addr,
  input  logic [DATA_W-1:0]     fifo_data,
  input  logic [DATA_W/8-1:0]   fifo_strb,
  output logic                  fifo_read,
  output logic [3:0]            awid,
  output logic [ADDR_W-1:0]     awaddr,
  output logic [7:0]            awlen,
  output logic [2:0]            awsize,
  output logic [1:0]            awburst,
  output logic                  awvalid,
  input  logic                  awready,
  output logic [DATA_W-1:0]     wdata,
  output logic [DATA_W/8-1:0]   wstrb,
  output logic                  wlast,
  output logic                  wvalid,
  input  logic                  wready,
  input  logic [3:0]            bid,
  input  logic [1:0]            bresp,
  input  logic                  bvalid,
  output logic                  bready,
  output logic                  idle,
  output logic                  bus_err
);

  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {IDLE, SEND, RESP} state_t;

  state_t              state_q, state_d;
  logic                awvalid_q, awvalid_d;
  logic                wvalid_q, wvalid_d;
  logic                bready_q, bready_d;
  logic                aw_done_q, aw_done_d;
  logic                w_done_q, w_done_d;
  logic                bus_err_q, bus_err_d;
  logic [ADDR_W-1:0]   awaddr_q, awaddr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]   wstrb_q, wstrb_d;
  logic                aw_fire, w_fire;
  logic                unused_bid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      bus_err_q <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
    end else begin
      state_q   <= state_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      bus_err_q <= bus_err_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    bready_d  = bready_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    bus_err_d = bus_err_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    aw_fire   = awvalid_q & awready;
    w_fire    = wvalid_q & wready;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          awaddr_d  = fifo_addr;
          wdata_d   = fifo_data;
          wstrb_d   = fifo_strb;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = SEND;
        end
      end
      SEND: begin
        // AW and W complete independently; move on once both have handshaked.
        if (aw_fire) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (w_fire) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        if (aw_done_d && w_done_d) begin
          bready_d = 1'b1;
          state_d  = RESP;
        end
      end
      RESP: begin
        if (bvalid) begin
          bready_d = 1'b0;
          if (bresp != 2'b00) bus_err_d = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Pop coincides with the B handshake so the head stays visible until done.
  assign fifo_read  = (state_q == RESP) & bvalid;
  assign idle       = (state_q == IDLE) & fifo_empty;
  assign bus_err    = bus_err_q;
  assign awid       = AXI_ID;
  assign awaddr     = awaddr_q;
  assign awlen      = 8'd0;
  assign awsize     = AXI_SIZE;
  assign awburst    = 2'b01;
  assign awvalid    = awvalid_q;
  assign wdata      = wdata_q;
  assign wstrb      = wstrb_q;
  assign wlast      = 1'b1;
  assign wvalid     = wvalid_q;
  assign bready     = bready_q;
  assign unused_bid = ^bid;

endmodule
